// File: rtl/tick_countdown_timer_if.sv
// Purpose: control and display bundle between game logic and the countdown timer.
// Latency: none; this file holds wires only.
// Backpressure: none; tick/start/pause/load are sampled every clock, with no handshake.
interface tick_countdown_timer_if;
  // Control from the game FSM / rate divider
  logic       tick;
  logic       start;
  logic       pause;
  logic       load;
  logic [2:0] load_min_t;
  logic [3:0] load_min_o;
  logic [2:0] load_sec_t;
  logic [3:0] load_sec_o;

  // Display digits and status back to the decoders / game FSM
  logic [2:0] min_t;
  logic [3:0] min_o;
  logic [2:0] sec_t;
  logic [3:0] sec_o;
  logic       running;
  logic       expired;
  logic       expire_pulse;

  // Side that drives the controls and observes the timer
  modport master (
    output tick, start, pause, load,
    output load_min_t, load_min_o, load_sec_t, load_sec_o,
    input  min_t, min_o, sec_t, sec_o,
    input  running, expired, expire_pulse
  );

  // The timer itself
  modport slave (
    input  tick, start, pause, load,
    input  load_min_t, load_min_o, load_sec_t, load_sec_o,
    output min_t, min_o, sec_t, sec_o,
    output running, expired, expire_pulse
  );
endinterface

// File: rtl/tick_countdown_timer.sv
// Purpose: BCD mm:ss countdown timer driven by a 1 Hz tick, with load/start/pause and expiry.
// Latency: 1 clock from tick/start/load to digits/status; all outputs are registered.
// Backpressure: none; each tick-high cycle is one second, and level controls are sampled every clock.
module tick_countdown_timer #(
  parameter int DEFAULT_MIN = 1,
  parameter int DEFAULT_SEC = 30
) (
  input logic                  clock,
  input logic                  resetn,
  tick_countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  // Reset digits: binary defaults split into BCD tens/ones
  localparam logic [2:0] DEF_MIN_T = 3'(DEFAULT_MIN / 10);
  localparam logic [3:0] DEF_MIN_O = 4'(DEFAULT_MIN % 10);
  localparam logic [2:0] DEF_SEC_T = 3'(DEFAULT_SEC / 10);
  localparam logic [3:0] DEF_SEC_O = 4'(DEFAULT_SEC % 10);

  state_e     state_q, state_d;
  logic [2:0] min_t_q, min_t_d;
  logic [3:0] min_o_q, min_o_d;
  logic [2:0] sec_t_q, sec_t_d;
  logic [3:0] sec_o_q, sec_o_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       pulse_q, pulse_d;

  // Sanitised load digits and the one-second decrement of the current value
  logic [2:0] ld_min_t, ld_sec_t, dec_min_t, dec_sec_t;
  logic [3:0] ld_min_o, ld_sec_o, dec_min_o, dec_sec_o;
  logic       cur_zero, dec_zero;

  // Clamp out-of-range BCD load digits so the display never shows garbage
  always_comb begin
    ld_min_t = (bus.load_min_t > 3'd5) ? 3'd5 : bus.load_min_t;
    ld_min_o = (bus.load_min_o > 4'd9) ? 4'd9 : bus.load_min_o;
    ld_sec_t = (bus.load_sec_t > 3'd5) ? 3'd5 : bus.load_sec_t;
    ld_sec_o = (bus.load_sec_o > 4'd9) ? 4'd9 : bus.load_sec_o;
  end

  // BCD decrement by one second, borrowing sec_o -> sec_t -> min_o -> min_t.
  // The result is used only when the value is nonzero, so 00:00 never wraps.
  always_comb begin
    dec_min_t = min_t_q;
    dec_min_o = min_o_q;
    dec_sec_t = sec_t_q;
    dec_sec_o = sec_o_q;
    if (sec_o_q != 4'd0) begin
      dec_sec_o = sec_o_q - 4'd1;
    end else begin
      dec_sec_o = 4'd9;
      if (sec_t_q != 3'd0) begin
        dec_sec_t = sec_t_q - 3'd1;
      end else begin
        dec_sec_t = 3'd5;
        if (min_o_q != 4'd0) begin
          dec_min_o = min_o_q - 4'd1;
        end else begin
          dec_min_o = 4'd9;
          dec_min_t = min_t_q - 3'd1;
        end
      end
    end
    cur_zero = (min_t_q == 3'd0) && (min_o_q == 4'd0) &&
               (sec_t_q == 3'd0) && (sec_o_q == 4'd0);
    dec_zero = (dec_min_t == 3'd0) && (dec_min_o == 4'd0) &&
               (dec_sec_t == 3'd0) && (dec_sec_o == 4'd0);
  end

  // Next-state, next-digit and registered-status logic for the control FSM
  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_o_d = min_o_q;
    sec_t_d = sec_t_q;
    sec_o_d = sec_o_q;

    case (state_q)
      IDLE: begin
        // Load beats start; start on 00:00 does nothing
        if (bus.load) begin
          min_t_d = ld_min_t;
          min_o_d = ld_min_o;
          sec_t_d = ld_sec_t;
          sec_o_d = ld_sec_o;
        end else if (bus.start && !cur_zero) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        // A tick coinciding with pause still counts; reaching zero beats pause
        if (bus.tick) begin
          min_t_d = dec_min_t;
          min_o_d = dec_min_o;
          sec_t_d = dec_sec_t;
          sec_o_d = dec_sec_o;
        end
        if (bus.tick && dec_zero) begin
          state_d = EXPIRED;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        // Resume only on start with pause released; load takes priority
        if (bus.load) begin
          min_t_d = ld_min_t;
          min_o_d = ld_min_o;
          sec_t_d = ld_sec_t;
          sec_o_d = ld_sec_o;
        end else if (bus.start && !bus.pause && !cur_zero) begin
          state_d = RUNNING;
        end
      end
      EXPIRED: begin
        // Digits sit at 00:00 until a fresh value is loaded
        if (bus.load) begin
          min_t_d = ld_min_t;
          min_o_d = ld_min_o;
          sec_t_d = ld_sec_t;
          sec_o_d = ld_sec_o;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUNNING);
    expired_d = (state_d == EXPIRED);
    pulse_d   = (state_d == EXPIRED) && (state_q != EXPIRED);
  end

  // State and status flags; status is registered alongside the state it mirrors
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
    end
  end

  // Digit registers; reset restores the parameter defaults
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      min_t_q <= DEF_MIN_T;
      min_o_q <= DEF_MIN_O;
      sec_t_q <= DEF_SEC_T;
      sec_o_q <= DEF_SEC_O;
    end else begin
      min_t_q <= min_t_d;
      min_o_q <= min_o_d;
      sec_t_q <= sec_t_d;
      sec_o_q <= sec_o_d;
    end
  end

  assign bus.min_t        = min_t_q;
  assign bus.min_o        = min_o_q;
  assign bus.sec_t        = sec_t_q;
  assign bus.sec_o        = sec_o_q;
  assign bus.running      = running_q;
  assign bus.expired      = expired_q;
  assign bus.expire_pulse = pulse_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Purpose: directed self-checking bench for tick_countdown_timer.
// Latency: checks are made 1 ns after each rising edge.
// Backpressure: none; stimulus is applied cycle by cycle.
module tb_tick_countdown_timer;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_err;

  tick_countdown_timer_if bus ();

  tick_countdown_timer #(
    .DEFAULT_MIN(1),
    .DEFAULT_SEC(30)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Display digits packed as 0xMMSS so hand-computed values read naturally
  function automatic logic [15:0] digits();
    return {1'b0, bus.min_t, bus.min_o, 1'b0, bus.sec_t, bus.sec_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [2:0] mt, input logic [3:0] mo,
                         input logic [2:0] st, input logic [3:0] so);
    bus.load       = 1'b1;
    bus.load_min_t = mt;
    bus.load_min_o = mo;
    bus.load_sec_t = st;
    bus.load_sec_o = so;
    cyc(1);
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1;
    cyc(1);
    bus.pause = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn         = 1'b0;
    bus.tick       = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.load       = 1'b0;
    bus.load_min_t = 3'd0;
    bus.load_min_o = 4'd0;
    bus.load_sec_t = 3'd0;
    bus.load_sec_o = 4'd0;

    // Reset state
    cyc(2);
    check("rst_digits", 32'(digits()), 32'h0130);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_expired", 32'(bus.expired), 32'd0);
    check("rst_pulse", 32'(bus.expire_pulse), 32'd0);
    resetn = 1'b1;
    cyc(1);

    // Tick ignored in IDLE
    do_tick();
    check("idle_tick_hold", 32'(digits()), 32'h0130);

    // Borrow across all four digits: 10:00 -> 09:59
    do_load(3'd1, 4'd0, 3'd0, 4'd0);
    check("load_1000", 32'(digits()), 32'h1000);
    do_start();
    check("start_running", 32'(bus.running), 32'd1);
    do_tick();
    check("borrow_0959", 32'(digits()), 32'h0959);

    // Pause, reload 01:00 in PAUSED, resume, one tick -> 00:59
    do_pause();
    check("paused_not_running", 32'(bus.running), 32'd0);
    do_load(3'd0, 4'd1, 3'd0, 4'd0);
    check("paused_load_0100", 32'(digits()), 32'h0100);
    do_start();
    do_tick();
    check("borrow_0059", 32'(digits()), 32'h0059);

    // Expiry from 00:02 with ticks two cycles apart
    do_pause();
    do_load(3'd0, 4'd0, 3'd0, 4'd2);
    do_start();
    do_tick();
    check("exp_0001", 32'(digits()), 32'h0001);
    check("exp_not_yet", 32'(bus.expired), 32'd0);
    cyc(1);
    do_tick();
    check("exp_0000", 32'(digits()), 32'h0000);
    check("exp_expired", 32'(bus.expired), 32'd1);
    check("exp_pulse_hi", 32'(bus.expire_pulse), 32'd1);
    check("exp_running_lo", 32'(bus.running), 32'd0);
    bus.tick = 1'b1;
    cyc(3);
    bus.tick = 1'b0;
    check("exp_pulse_lo", 32'(bus.expire_pulse), 32'd0);
    check("exp_hold_0000", 32'(digits()), 32'h0000);
    check("exp_still", 32'(bus.expired), 32'd1);
    do_start();
    check("exp_start_ignored", 32'(bus.expired), 32'd1);

    // Load in EXPIRED -> new value, back to IDLE
    do_load(3'd0, 4'd0, 3'd3, 4'd0);
    check("exp_load_0030", 32'(digits()), 32'h0030);
    check("exp_load_idle_exp", 32'(bus.expired), 32'd0);
    check("exp_load_idle_run", 32'(bus.running), 32'd0);

    // Pause with simultaneous tick, ticks ignored, start+pause stays paused
    do_start();
    bus.pause = 1'b1;
    bus.tick  = 1'b1;
    cyc(1);
    bus.pause = 1'b0;
    bus.tick  = 1'b0;
    check("pause_tick_0029", 32'(digits()), 32'h0029);
    check("pause_state", 32'(bus.running), 32'd0);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      cyc(1);
    end
    check("pause_hold_0029", 32'(digits()), 32'h0029);
    bus.start = 1'b1;
    bus.pause = 1'b1;
    cyc(1);
    bus.pause = 1'b0;
    check("start_pause_stay", 32'(bus.running), 32'd0);
    cyc(1);
    bus.start = 1'b0;
    check("resume_running", 32'(bus.running), 32'd1);
    do_tick();
    check("resume_0028", 32'(digits()), 32'h0028);

    // Load while RUNNING is ignored
    do_load(3'd4, 4'd4, 3'd4, 4'd4);
    check("run_load_ignored", 32'(digits()), 32'h0028);
    check("run_load_running", 32'(bus.running), 32'd1);

    // Asynchronous reset mid-count at 00:45
    do_pause();
    do_load(3'd0, 4'd0, 3'd4, 4'd5);
    do_start();
    check("pre_reset_0045", 32'(digits()), 32'h0045);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_digits", 32'(digits()), 32'h0130);
    check("arst_running", 32'(bus.running), 32'd0);
    check("arst_expired", 32'(bus.expired), 32'd0);
    check("arst_pulse", 32'(bus.expire_pulse), 32'd0);
    #1;
    resetn = 1'b1;
    cyc(1);
    do_tick();
    check("arst_idle_tick", 32'(digits()), 32'h0130);

    // Start at 00:00 in IDLE is ignored
    do_load(3'd0, 4'd0, 3'd0, 4'd0);
    do_start();
    check("zero_start_run", 32'(bus.running), 32'd0);
    check("zero_start_exp", 32'(bus.expired), 32'd0);

    // Out-of-range load digits saturate
    do_load(3'd7, 4'hC, 3'd6, 4'hF);
    check("sat_5959", 32'(digits()), 32'h5959);

    // Load and start together in IDLE: load wins, stays IDLE
    bus.start = 1'b1;
    do_load(3'd0, 4'd2, 3'd0, 4'd0);
    bus.start = 1'b0;
    check("ld_st_digits", 32'(digits()), 32'h0200);
    check("ld_st_idle", 32'(bus.running), 32'd0);
    cyc(1);
    check("ld_st_still_idle", 32'(bus.running), 32'd0);

    // Tick held high for three cycles gives three decrements
    do_start();
    bus.tick = 1'b1;
    cyc(3);
    bus.tick = 1'b0;
    check("held_tick_0157", 32'(digits()), 32'h0157);
    check("held_tick_run", 32'(bus.running), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
